// File: rtl/tick_period_monitor.sv
// Measures the rising-edge-to-rising-edge period of a tick stream in clk cycles,
// flags periods that differ from the expected one, and saturates on lost ticks.
module tick_period_monitor #(
    parameter int CNT_SIZE      = 8,
    parameter int EXP_PERIOD    = 10,
    parameter int TICK_CNT_SIZE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     tick_in,
    output logic [CNT_SIZE-1:0]      period_out,
    output logic                     period_valid,
    output logic                     mismatch,
    output logic [TICK_CNT_SIZE-1:0] tick_count,
    output logic                     ovf
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        SAT
    } state_t;

    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] EXP_VAL = CNT_SIZE'(EXP_PERIOD);

    state_t                     state;
    state_t                     state_nxt;
    logic                       tick_d;
    logic                       tick_edge;
    logic [CNT_SIZE-1:0]        cnt;
    logic [CNT_SIZE-1:0]        cnt_nxt;
    logic [CNT_SIZE-1:0]        cnt_inc;
    logic [CNT_SIZE-1:0]        period_nxt;
    logic                       valid_nxt;
    logic                       mismatch_nxt;
    logic [TICK_CNT_SIZE-1:0]   tick_count_nxt;
    logic                       ovf_nxt;

    // Level-to-edge conversion; a held-high tick yields only one edge.
    assign tick_edge = tick_in & ~tick_d & en;
    assign cnt_inc   = cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_d       <= 1'b0;
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            tick_count   <= '0;
            ovf          <= 1'b0;
        end else begin
            state        <= state_nxt;
            tick_d       <= tick_in;
            cnt          <= cnt_nxt;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
            mismatch     <= mismatch_nxt;
            tick_count   <= tick_count_nxt;
            ovf          <= ovf_nxt;
        end
    end

    // With en low everything keeps its value and the pulse outputs drop.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        period_nxt     = period_out;
        valid_nxt      = 1'b0;
        mismatch_nxt   = 1'b0;
        tick_count_nxt = tick_count;
        ovf_nxt        = ovf;
        if (en) begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (tick_edge) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    // An edge wins over reaching the saturation threshold.
                    if (tick_edge) begin
                        period_nxt     = cnt;
                        valid_nxt      = 1'b1;
                        mismatch_nxt   = (cnt != EXP_VAL);
                        tick_count_nxt = tick_count + TICK_CNT_SIZE'(1);
                        cnt_nxt        = CNT_ONE;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_nxt = SAT;
                            ovf_nxt   = 1'b1;
                        end
                    end
                end
                SAT: begin
                    cnt_nxt = CNT_MAX;
                    if (tick_edge) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed-vector bench for tick_period_monitor at default parameters
// (8-bit period counter, expected period 10, 2-bit measurement counter).
module tb_tick_period_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tick_in;
    logic [7:0] period_out;
    logic       period_valid;
    logic       mismatch;
    logic [1:0] tick_count;
    logic       ovf;

    int testsRun    = 0;
    int testsFailed = 0;
    int sawPulse    = 0;

    always #5 clk = ~clk;

    tick_period_monitor #(
        .CNT_SIZE     (8),
        .EXP_PERIOD   (10),
        .TICK_CNT_SIZE(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .tick_in     (tick_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .mismatch    (mismatch),
        .tick_count  (tick_count),
        .ovf         (ovf)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs just after the edge.
    task automatic applyStimulus(input logic t, input logic e);
        tick_in = t;
        en      = e;
        @(posedge clk);
        #1;
        if (period_valid || mismatch) sawPulse++;
    endtask

    task automatic idle(input int n, input logic e = 1'b1);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, e);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        tick_in = 1'b0;
        en      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkMeasure(input string tag, input int per, input int mis, input int cnt);
        checkOutput({tag, "_valid"}, int'(period_valid), 1);
        checkOutput({tag, "_period"}, int'(period_out), per);
        checkOutput({tag, "_mismatch"}, int'(mismatch), mis);
        checkOutput({tag, "_count"}, int'(tick_count), cnt);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        tick_in = 1'b0;

        // Reset state, then nominal period of 10 with counter wrap.
        doReset();
        checkOutput("rst_period", int'(period_out), 0);
        checkOutput("rst_valid", int'(period_valid), 0);
        checkOutput("rst_mismatch", int'(mismatch), 0);
        checkOutput("rst_count", int'(tick_count), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("p10_arm_valid", int'(period_valid), 0);
        idle(9);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkMeasure($sformatf("p10_%0d", i), 10, 0, i % 4);
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("p10_%0d_pulse_width", i), int'(period_valid), 0);
            idle(8);
        end

        // Period of 7 is reported as a mismatch.
        doReset();
        applyStimulus(1'b1, 1'b1);
        idle(6);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkMeasure($sformatf("p7_%0d", i), 7, 1, i);
            idle(6);
        end

        // Edge on the cycle the count would saturate: measurement wins.
        doReset();
        applyStimulus(1'b1, 1'b1);
        idle(253);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("edge_at_sat", 254, 1, 1);
        checkOutput("edge_at_sat_ovf", int'(ovf), 0);

        // Lost ticks: saturate, sticky ovf, re-arm without a measurement.
        doReset();
        applyStimulus(1'b1, 1'b1);
        idle(253);
        checkOutput("sat_ovf_before", int'(ovf), 0);
        idle(1);
        checkOutput("sat_ovf_set", int'(ovf), 1);
        idle(46);
        sawPulse = 0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("sat_edge_no_valid", sawPulse, 0);
        checkOutput("sat_edge_period", int'(period_out), 0);
        checkOutput("sat_edge_count", int'(tick_count), 0);
        idle(9);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("after_sat", 10, 0, 1);
        checkOutput("after_sat_ovf", int'(ovf), 1);

        // en low for 30 cycles with ticks present: only enabled cycles count.
        doReset();
        applyStimulus(1'b1, 1'b1);
        idle(4);
        sawPulse = 0;
        for (int j = 0; j < 30; j++) applyStimulus((j % 10) == 5, 1'b0);
        checkOutput("en_off_no_pulse", sawPulse, 0);
        checkOutput("en_off_count", int'(tick_count), 0);
        idle(7);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("en_resume", 12, 1, 1);

        // Reset in the middle of a period discards the partial count.
        doReset();
        applyStimulus(1'b1, 1'b1);
        idle(9);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("pre_reset", 10, 0, 1);
        idle(3);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("mid_reset_period", int'(period_out), 0);
        checkOutput("mid_reset_count", int'(tick_count), 0);
        checkOutput("mid_reset_valid", int'(period_valid), 0);
        idle(5);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_reset_rearm_valid", int'(period_valid), 0);
        idle(9);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("post_reset", 10, 0, 1);

        // Held-high tick is a single edge.
        doReset();
        sawPulse = 0;
        for (int j = 0; j < 50; j++) applyStimulus(1'b1, 1'b1);
        checkOutput("hold_high_no_pulse", sawPulse, 0);
        idle(10);
        applyStimulus(1'b1, 1'b1);
        checkMeasure("hold_high", 60, 1, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
